// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO serial drain path.
// No logic; imported by the transmitter and its bit timer.
// Frame format: start bit, DATA_W data bits LSB first, stop bit.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_W_DEF = 16;

  // Serial bits per frame: one start bit, the data bits and one stop bit.
  localparam int FRAME_BITS = DATA_W_DEF + 2;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT period.
// Latency: tick is asserted CLKS_PER_BIT-1 cycles after clear drops.
// Backpressure: none; clear holds the count at zero.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running modulo-CLKS_PER_BIT count, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: pops one word at a time and shifts it out as a serial frame.
// Latency: the start bit begins 2 cycles after the pop; a frame lasts (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: pops only when idle and the FIFO is not empty, at most once per frame.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       frames_sent
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              tick;
  logic              timer_clear;

  // The bit timer only runs while a frame is on the line, so every bit
  // period starts from a zero count once FETCH has passed.
  assign timer_clear = (state == IDLE) || (state == FETCH);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .tick (tick)
  );

  // Pop in the same cycle the FSM commits to FETCH; the FIFO presents the
  // word on the next cycle. Reset masks the pop so a pending word waits.
  assign fifo_rd_en = !reset && (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE);

  // Frame sequencer: tx is registered, so each state loads the line level
  // that the following state must present.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      shreg       <= '0;
      bit_idx     <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          shreg   <= fifo_dout;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_IDX) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            frames_sent <= frames_sent + 16'd1;
            state       <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Testbench for fifo_serial_tx: FIFO model, serial receiver and scoreboard.
// Frames are decoded from tx and compared against words queued at push time.
// Directed scenarios cover reset, single and back-to-back frames, empty guard, reset mid-frame and wrap.
module tb_fifo_serial_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // FIFO model storage, monotonic pointers (few words per run)
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [15:0] exp_q [$];

  int rd_pulses    = 0;
  int rd_viol      = 0;
  int last_rd_cyc  = -100;
  int stop_end_cyc = -100;
  int last_gap     = -1;
  int frames_rx    = 0;
  bit mon_en       = 1'b1;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  fifo_serial_tx #(
    .DATA_W      (16),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  // FIFO read port: dout updates on the edge that samples rd_en
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Pop bookkeeping
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      last_rd_cyc = cyc;
      if (fifo_empty) rd_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input bit scored);
    mem[wr_ptr] = w;
    wr_ptr++;
    if (scored) exp_q.push_back(w);
  endtask

  task automatic wait_frames(input int n, input string name);
    int budget;
    budget = 400;
    while (frames_rx < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, frames_rx, n);
  endtask

  // Monitor: decode each frame from tx and compare against the scoreboard
  logic [15:0] rx_word;
  logic [15:0] frames_before;
  logic [15:0] exp_w;
  int          start_cyc;
  bit          shape_ok;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        start_cyc     = cyc;
        frames_before = frames_sent;
        check("start_latency", start_cyc - last_rd_cyc, 2);
        last_gap = start_cyc - stop_end_cyc - 1;
        shape_ok = 1'b1;
        for (int i = 1; i < 4; i++) begin
          @(negedge clk);
          if (tx !== 1'b0) shape_ok = 1'b0;
        end
        for (int b = 0; b < 16; b++) begin
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) rx_word[b] = tx;
            else if (tx !== rx_word[b]) shape_ok = 1'b0;
          end
        end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (tx !== 1'b1) shape_ok = 1'b0;
          if (frames_sent !== frames_before) shape_ok = 1'b0;
        end
        stop_end_cyc = cyc;
        check("frame_shape", {31'd0, shape_ok}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {16'd0, rx_word}, 32'hDEAD_BEEF);
        end else begin
          exp_w = exp_q.pop_front();
          check("frame_data", {16'd0, rx_word}, {16'd0, exp_w});
        end
        @(negedge clk);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        check("frames_inc", {16'd0, frames_sent}, {16'd0, frames_before + 16'd1});
        frames_rx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int p0;
    int tx_low;
    int t0;
    int budget;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset while idle
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frames", {16'd0, frames_sent}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Single word 0x0055
    p0 = rd_pulses;
    push(16'h0055, 1'b1);
    wait_frames(1, "single_timeout");
    check("single_rd_pulses", rd_pulses - p0, 1);
    check("single_frames_sent", {16'd0, frames_sent}, 32'd1);

    // Back-to-back 0x8001, 0xFFFF
    @(negedge clk);
    p0 = rd_pulses;
    push(16'h8001, 1'b1);
    push(16'hFFFF, 1'b1);
    wait_frames(3, "b2b_timeout");
    check("b2b_gap", last_gap, 2);
    check("b2b_rd_pulses", rd_pulses - p0, 2);
    check("b2b_frames_sent", {16'd0, frames_sent}, 32'd3);

    // Empty guard
    p0 = rd_pulses;
    tx_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    check("empty_rd_pulses", rd_pulses - p0, 0);
    check("empty_tx_low", tx_low, 0);

    // Reset during data bit 7 of 0x1234, with another word pending
    mon_en = 1'b0;
    p0 = rd_pulses;
    push(16'h1234, 1'b0);
    budget = 50;
    while (rd_pulses == p0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_pop_seen", rd_pulses - p0, 1);
    t0 = last_rd_cyc;
    budget = 100;
    while (cyc < t0 + 35 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_bit7", {31'd0, tx}, 32'd0);
    push(16'hA5C3, 1'b1);
    p0 = rd_pulses;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frames", {16'd0, frames_sent}, 32'd0);
    check("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    check("midrst_rd_en_hold", {31'd0, fifo_rd_en}, 32'd0);
    check("midrst_no_pop", rd_pulses - p0, 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    wait_frames(4, "after_rst_timeout");
    check("after_rst_frames", {16'd0, frames_sent}, 32'd1);

    // frames_sent wrap
    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    check("wrap_preload", {16'd0, frames_sent}, 32'h0000_FFFF);
    push(16'h0F0F, 1'b1);
    wait_frames(5, "wrap_timeout");
    check("wrap_frames", {16'd0, frames_sent}, 32'd0);

    repeat (5) @(negedge clk);
    check("rd_en_while_empty", rd_viol, 0);
    check("scoreboard_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
